ps2_move_ctrl: RTL and testbench

//  System-clock controller that sequences the PS/2 keyboard datapath for the 2048 game.
//  - Oversamples PS2_CLK/PS2_DATA, deserialises and checks each 11-bit frame.
//  - Decodes make/break/extended scan codes into one-shot move commands.
//  - Queues moves and hands them to the game engine over a valid/ready handshake.

---
 rtl/ps2_move_ctrl_pkg.sv | 59 +++++
 rtl/ps2_move_ctrl_frame_rx.sv | 92 +++++++++
 rtl/ps2_move_ctrl.sv | 89 ++++++++
 tb/tb_ps2_move_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_move_ctrl_pkg.sv
// rtl/ps2_move_ctrl_pkg.sv - direction codes, scan codes, frame states and key map
package ps2_move_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } move_t;

  // Arrow keys only exist as extended codes; WASD only as plain codes.
  function automatic move_t map_code(input logic [7:0] code, input logic ext,
                                     input logic wasd);
    move_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        SC_DOWN:  begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_LEFT:  begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_RIGHT: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        default:  ;
      endcase
    end else if (wasd) begin
      case (code)
        SC_W:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
        SC_S:    begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
        SC_A:    begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
        SC_D:    begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
        default: ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_move_ctrl_frame_rx.sv
// rtl/ps2_move_ctrl_frame_rx.sv - PS/2 line synchroniser, 11-bit frame receiver and watchdog
module ps2_move_ctrl_frame_rx import ps2_move_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic ps2_fall;
  frame_state_t state, state_nxt;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic par_ok;
  logic [WD_W-1:0] wd_cnt;
  logic done_ok, done_err, timeout;

  assign ps2_fall = clk_prev & ~clk_s2;
  assign rx_byte  = shreg;

  // wd_cnt is cycles since the last fall; deciding one cycle early lands the
  // registered frame_err exactly TIMEOUT_CYC cycles after that fall.
  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    timeout   = (state != ST_IDLE) && !ps2_fall && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (ps2_fall) begin
      case (state)
        ST_IDLE:   if (!dat_s2) state_nxt = ST_SHIFT;
        ST_SHIFT:  if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (dat_s2 && par_ok) done_ok = 1'b1;
          else done_err = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      state     <= ST_IDLE;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      par_ok    <= 1'b0;
      wd_cnt    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      clk_prev  <= clk_s2;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      state     <= state_nxt;
      byte_vld  <= done_ok;
      frame_err <= done_err | timeout;
      if (ps2_fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= 3'd0;
          ST_SHIFT: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_ok <= ^{shreg, dat_s2};
          default:   ;
        endcase
      end
      if (ps2_fall) wd_cnt <= WD_W'(1);
      else if (state == ST_IDLE) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: rtl/ps2_move_ctrl.sv
// rtl/ps2_move_ctrl.sv - PS/2 keyboard to 2048 move command controller
// Decodes make/break/extended codes into one-shot moves and queues them for the engine.
module ps2_move_ctrl import ps2_move_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 4,
  parameter bit ACCEPT_WASD = 1'b1
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_vld;

  ps2_move_ctrl_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (CLK100MHZ),
    .resetn    (CPU_RESETN),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  logic       ext, brk;
  logic [3:0] held;
  move_t      cand;
  logic       make_new;

  assign cand     = map_code(rx_byte, ext, ACCEPT_WASD);
  assign make_new = byte_vld && cand.hit && !brk && !held[cand.dir];

  // held follows make/break even when the push itself is dropped for overflow.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      held <= 4'h0;
    end else if (byte_vld) begin
      if (rx_byte == SC_EXT) ext <= 1'b1;
      else if (rx_byte == SC_BRK) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (cand.hit) held[cand.dir] <= !brk;
      end
    end
  end

  dir_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, pop, push;

  assign full       = (count == FULL_CNT);
  assign move_valid = (count != '0);
  assign move_dir   = mem[rd_ptr];
  assign pop        = move_valid & move_ready;
  assign push       = make_new & (!full | pop);

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= DIR_UP;
    end else begin
      overflow <= make_new & full & !pop;
      if (push) begin
        mem[wr_ptr] <= cand.dir;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_ps2_move_ctrl.sv
// tb/tb_ps2_move_ctrl.sv - directed self-checking bench for ps2_move_ctrl
module tb_ps2_move_ctrl;

  localparam int TO   = 200;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic resetn, ps2_clk, ps2_data, move_ready;
  logic move_valid, frame_err, overflow;
  logic [1:0] move_dir;
  logic nw_move_valid, nw_frame_err, nw_overflow;
  logic [1:0] nw_move_dir;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fall = 0;
  int rise_cyc = 0;
  int err_cyc = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int nw_cnt = 0;
  logic mv_prev = 1'b0;
  logic nw_prev = 1'b0;
  logic [1:0] got[$];

  ps2_move_ctrl #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(4), .ACCEPT_WASD(1'b1)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(resetn), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  ps2_move_ctrl #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(4), .ACCEPT_WASD(1'b0)) dut_nw (
    .CLK100MHZ(clk), .CPU_RESETN(resetn), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .move_valid(nw_move_valid), .move_dir(nw_move_dir), .move_ready(move_ready),
    .frame_err(nw_frame_err), .overflow(nw_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (move_valid && move_ready) got.push_back(move_dir);
    if (move_valid && !mv_prev) rise_cyc = cyc;
    mv_prev = move_valid;
    if (frame_err) begin err_cnt++; err_cyc = cyc; end
    if (overflow) ovf_cnt++;
    if (nw_move_valid && !nw_prev) nw_cnt++;
    nw_prev = nw_move_valid;
  end

  task automatic clear_mon();
    got.delete();
    err_cnt = 0;
    ovf_cnt = 0;
    nw_cnt  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_edge(input logic d);
    ps2_data = d;
    idle(HALF);
    ps2_clk = 1'b0;
    last_fall = cyc;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_edge(f[i]);
    ps2_data = 1'b1;
    idle(HALF);
  endtask

  task automatic test_reset();
    resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; move_ready = 1'b0;
    idle(5);
    @(negedge clk);
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", move_valid); end
    total++; if (move_dir !== 2'd0) begin bad++; $display("FAIL reset_dir got=%0d want=0", move_dir); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    idle(1);
    resetn = 1'b1;
    idle(5);
  endtask

  task automatic test_latency();
    move_ready = 1'b1;
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    idle(20);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL lat_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0] !== 2'd0) begin bad++; $display("FAIL lat_dir got=%0d want=0", got[0]); end
    end
    // two synchroniser cycles before the fall is seen, then fall -> byte_vld -> move_valid
    total++; if (rise_cyc !== last_fall + 4) begin bad++; $display("FAIL lat_cycle got=%0d want=%0d", rise_cyc, last_fall + 4); end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
  endtask

  task automatic test_typematic();
    clear_mon();
    for (int i = 0; i < 3; i++) begin send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0); end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h74, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    idle(20);
    total++; if (got.size() !== 2) begin bad++; $display("FAIL typ_count got=%0d want=2", got.size()); end
    else begin
      total++; if (got[0] !== 2'd3) begin bad++; $display("FAIL typ_dir0 got=%0d want=3", got[0]); end
      total++; if (got[1] !== 2'd3) begin bad++; $display("FAIL typ_dir1 got=%0d want=3", got[1]); end
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h74, 1'b0);
  endtask

  task automatic test_parity();
    clear_mon();
    send_byte(8'h1C, 1'b1);
    idle(10);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL par_err got=%0d want=1", err_cnt); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL par_nomove got=%0d want=0", got.size()); end
    send_byte(8'h1C, 1'b0);
    idle(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL par_good_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0] !== 2'd2) begin bad++; $display("FAIL par_good_dir got=%0d want=2", got[0]); end
    end
    send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
  endtask

  task automatic test_timeout();
    clear_mon();
    ps2_edge(1'b0);
    for (int i = 0; i < 5; i++) ps2_edge(i[0]);
    ps2_data = 1'b1;
    idle(TO * 3 / 2);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL to_err got=%0d want=1", err_cnt); end
    total++; if (err_cyc !== last_fall + 2 + TO) begin bad++; $display("FAIL to_cycle got=%0d want=%0d", err_cyc, last_fall + 2 + TO); end
    send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
    idle(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL to_next_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0] !== 2'd1) begin bad++; $display("FAIL to_next_dir got=%0d want=1", got[0]); end
    end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h72, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] arrows [4];
    arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
    move_ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 4; i++) begin send_byte(8'hE0, 1'b0); send_byte(arrows[i], 1'b0); end
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'h1D, 1'b0);
    idle(10);
    total++; if (ovf_cnt !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d want=1", ovf_cnt); end
    total++; if (move_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", move_valid); end
    total++; if (move_dir !== 2'd0) begin bad++; $display("FAIL ovf_head got=%0d want=0", move_dir); end
    move_ready = 1'b1;
    idle(10);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL ovf_drain_count got=%0d want=4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (got[i] !== 2'(i)) begin bad++; $display("FAIL ovf_drain_%0d got=%0d want=%0d", i, got[i], i); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_byte(8'hE0, 1'b0);
    ps2_edge(1'b0);
    for (int i = 0; i < 3; i++) ps2_edge(1'b1);
    resetn = 1'b0;
    idle(3);
    @(negedge clk);
    total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", move_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_ferr got=%b want=0", frame_err); end
    idle(1);
    resetn = 1'b1;
    idle(5);
    send_byte(8'h75, 1'b0);
    idle(10);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL rst_ext_cleared got=%0d want=0", got.size()); end
    send_byte(8'h1D, 1'b0);
    idle(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL wasd_count got=%0d want=1", got.size()); end
    else begin
      total++; if (got[0] !== 2'd0) begin bad++; $display("FAIL wasd_dir got=%0d want=0", got[0]); end
    end
    total++; if (nw_cnt !== 0) begin bad++; $display("FAIL nowasd_moves got=%0d want=0", nw_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_typematic();
    test_parity();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
